// File: rtl/ones_comp_rx.sv
// One's-complement serial receiver: start, WIDTH inverted data bits (LSB first),
// optional parity (ONES_COMP_PARITY_EN), stop; true word out via one-entry holding reg.
module ones_comp_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef ONES_COMP_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             last_bit, stop_smp, word_done, bad_stop, load;

  assign last_bit  = (cnt == CW'(WIDTH-1));
  assign word_done = stop_smp & in_data;
  assign bad_stop  = stop_smp & ~in_data;
  // A completing word may take the slot the consumer is draining this same edge.
  assign load      = word_done & (~out_valid | out_ready);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    stop_smp  = 1'b0;
    if (in_valid) begin
      case (state)
        IDLE: if (!in_data) state_nxt = DATA;
        DATA: if (last_bit) begin
`ifdef ONES_COMP_PARITY_EN
          state_nxt = PAR;
`else
          state_nxt = STOP;
`endif
        end
`ifdef ONES_COMP_PARITY_EN
        PAR:  state_nxt = STOP;
`endif
        STOP: begin
          state_nxt = IDLE;
          stop_smp  = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_err <= bad_stop;
      if (state == IDLE) begin
        cnt <= '0;
      end else if (state == DATA && in_valid) begin
        // Line carries the complement; store the true bit directly.
        shreg[cnt] <= ~in_data;
        if (!last_bit) cnt <= cnt + 1'b1;
      end
      if (load) begin
        out_data  <= shreg;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (word_done && !load) overrun <= 1'b1;
    end
  end

`ifdef ONES_COMP_PARITY_EN
  logic par_bad, parity_err_r;

  // Even parity over the bits as transmitted, i.e. the complemented word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bad      <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      if (state == PAR && in_valid) par_bad <= in_data ^ (^(~shreg));
      parity_err_r <= stop_smp & par_bad;
    end
  end

  assign parity_err = parity_err_r;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ones_comp_rx.sv
// Directed bench for ones_comp_rx (WIDTH=8); parity steps compiled in with ONES_COMP_PARITY_EN.
module tb_ones_comp_rx;

  logic       clk, rst, in_valid, in_data, out_ready;
  logic [7:0] out_data;
  logic       out_valid, frame_err, overrun, parity_err, busy;
  int         n_chk  = 0;
  int         n_pass = 0;

  ones_comp_rx #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One strobed bit; returns 1 time unit after the sampling edge.
  task automatic strobe(input logic b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 1'b1;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  // Start bit, 8 line bits LSB first, then parity bit when enabled.
  task automatic send_body(input logic [7:0] tx, input logic par);
    strobe(1'b0);
    for (int i = 0; i < 8; i++) strobe(tx[i]);
`ifdef ONES_COMP_PARITY_EN
    strobe(par);
`else
    if (par) ; // no parity bit on the line in this build
`endif
  endtask

  task automatic send_frame(input logic [7:0] tx, input logic par, input logic stop);
    send_body(tx, par);
    strobe(stop);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = 1'b1; out_ready = 1'b1;
    #2;
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_parity_err", parity_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk); #1; rst = 1'b1;
    idle_cycle();

    // Idle-line 1s do not start a frame
    strobe(1'b1);
    chk("idle_busy", busy, 1'b0);

    // Line 0x5A -> true 0xA5
    strobe(1'b0);
    chk("t1_busy_after_start", busy, 1'b1);
    for (int i = 0; i < 8; i++) strobe(((8'h5A >> i) & 8'h01) != 0);
`ifdef ONES_COMP_PARITY_EN
    strobe(1'b0);
`endif
    chk("t1_busy_before_stop", busy, 1'b1);
    strobe(1'b1);
    chk("t1_out_valid", out_valid, 1'b1);
    chk("t1_out_data", out_data, 8'hA5);
    chk("t1_frame_err", frame_err, 1'b0);
    chk("t1_parity_err", parity_err, 1'b0);
    chk("t1_busy_after_stop", busy, 1'b0);
    idle_cycle();
    chk("t1_drained", out_valid, 1'b0);

    // Bad stop bit: discarded, frame_err one pulse
    send_frame(8'h00, 1'b0, 1'b0);
    chk("t2_frame_err", frame_err, 1'b1);
    chk("t2_out_valid", out_valid, 1'b0);
    chk("t2_busy", busy, 1'b0);
    idle_cycle();
    chk("t2_frame_err_pulse", frame_err, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1);
    chk("t2_next_valid", out_valid, 1'b1);
    chk("t2_next_data", out_data, 8'h00);
    idle_cycle();

    // Holding register full -> overrun, first word kept
    out_ready = 1'b0;
    send_frame(8'hEE, 1'b0, 1'b1);
    chk("t3_first_valid", out_valid, 1'b1);
    chk("t3_first_data", out_data, 8'h11);
    chk("t3_no_overrun_yet", overrun, 1'b0);
    send_frame(8'hDD, 1'b0, 1'b1);
    chk("t3_data_kept", out_data, 8'h11);
    chk("t3_overrun", overrun, 1'b1);
    chk("t3_valid_held", out_valid, 1'b1);
    out_ready = 1'b1;
    idle_cycle();
    chk("t3_drained", out_valid, 1'b0);
    chk("t3_overrun_sticky", overrun, 1'b1);

    // Load on the same edge the prior word drains
    pulse_reset();
    chk("t4_overrun_cleared", overrun, 1'b0);
    out_ready = 1'b0;
    send_frame(8'hCC, 1'b0, 1'b1);
    chk("t4_first_data", out_data, 8'h33);
    send_body(8'hBB, 1'b0);
    out_ready = 1'b1;
    strobe(1'b1);
    chk("t4_valid_stays", out_valid, 1'b1);
    chk("t4_new_data", out_data, 8'h44);
    chk("t4_no_overrun", overrun, 1'b0);
    idle_cycle();
    chk("t4_drained", out_valid, 1'b0);

    // Reset mid-frame, then a clean 0x3C frame back-to-back style
    strobe(1'b0);
    strobe(1'b1); strobe(1'b0); strobe(1'b1); strobe(1'b0);
    rst = 1'b0;
    #1;
    chk("t5_busy_in_reset", busy, 1'b0);
    chk("t5_data_in_reset", out_data, 8'h00);
    @(posedge clk); #1; rst = 1'b1;
    chk("t5_busy_after_reset", busy, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b1);
    chk("t5_valid", out_valid, 1'b1);
    chk("t5_data", out_data, 8'h3C);
    // Next start bit on the very next strobe after the stop bit
    send_frame(8'h0F, 1'b0, 1'b1);
    chk("t5_b2b_data", out_data, 8'hF0);
    chk("t5_b2b_valid", out_valid, 1'b1);
    idle_cycle();

`ifdef ONES_COMP_PARITY_EN
    // Line 0x5A carries four 1s: parity bit 1 is wrong
    send_frame(8'h5A, 1'b1, 1'b1);
    chk("t6_bad_par_data", out_data, 8'hA5);
    chk("t6_bad_par_valid", out_valid, 1'b1);
    chk("t6_parity_err", parity_err, 1'b1);
    idle_cycle();
    chk("t6_parity_err_pulse", parity_err, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1);
    chk("t6_good_par_data", out_data, 8'hA5);
    chk("t6_no_parity_err", parity_err, 1'b0);
    idle_cycle();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
